// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_fade_pwm
// Brief    : Per-LED PWM dimmer with a decaying afterglow behind the pattern.
// Revision : 1.0 - initial release
// ============================================================================
module led_fade_pwm #(
  parameter int MXDECAY = 18,
  parameter int MXPWM   = 4,
  parameter int INVERT  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] pat,
  input  logic       pat_en,
  input  logic [1:0] fade_rate,
  input  logic [3:0] bright,
  output logic [7:0] led,
  output logic       dark
);

  localparam int         C_DW      = MXDECAY + 1;
  localparam logic [7:0] C_LED_OFF = (INVERT != 0) ? 8'hFF : 8'h00;

  logic [1:0]         r_rst_sync;
  logic               w_run;
  logic [MXDECAY-1:0] r_dpre;
  logic [MXDECAY:0]   w_dsum;
  logic               r_tick;
  logic [7:0][3:0]    r_lvl;
  logic [3:0]         r_pwm_cnt;
  logic               w_pstep;
  logic [7:0]         w_on;

  // Release is synchronised; all state advances only once this chain is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run  = r_rst_sync[1];
  assign w_dsum = {1'b0, r_dpre} + C_DW'(fade_rate) + C_DW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dpre <= '0;
      r_tick <= 1'b0;
    end else if (w_run) begin
      r_dpre <= w_dsum[MXDECAY-1:0];
      r_tick <= w_dsum[MXDECAY];
    end
  end

  // A pattern load takes priority over a coincident decay step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl <= '0;
    end else if (w_run) begin
      for (int i = 0; i < 8; i++) begin
        if (pat_en && pat[i])                  r_lvl[i] <= bright;
        else if (r_tick && (r_lvl[i] != 4'd0)) r_lvl[i] <= r_lvl[i] - 4'd1;
      end
    end
  end

  generate
    if (MXPWM == 0) begin : g_pre_none
      assign w_pstep = 1'b1;
    end else begin : g_pre
      logic [MXPWM-1:0] r_ppre;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   r_ppre <= '0;
        else if (w_run) r_ppre <= r_ppre + MXPWM'(1);
      end
      assign w_pstep = &r_ppre;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_pwm_cnt <= 4'd0;
    else if (w_run && w_pstep) r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  always_comb begin
    w_on = 8'h00;
    for (int i = 0; i < 8; i++) w_on[i] = (r_pwm_cnt < r_lvl[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led  <= C_LED_OFF;
      dark <= 1'b1;
    end else begin
      led  <= w_on ^ C_LED_OFF;
      dark <= (r_lvl == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fade_pwm
// Brief    : Scoreboard bench for led_fade_pwm (normal and inverted outputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_fade_pwm;

  logic       clock = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       rst_b_n = 1'b0;
  logic [7:0] pat = 8'h00;
  logic       pat_en = 1'b0;
  logic [1:0] fade_rate = 2'd0;
  logic [3:0] bright = 4'd0;
  logic [7:0] led_a, led_b;
  logic       dark_a, dark_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [2:0] idx;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  led_fade_pwm #(.MXDECAY(4), .MXPWM(0), .INVERT(0)) u_a (
    .clock(clock), .reset_n(rst_a_n), .pat(pat), .pat_en(pat_en),
    .fade_rate(fade_rate), .bright(bright), .led(led_a), .dark(dark_a)
  );

  led_fade_pwm #(.MXDECAY(4), .MXPWM(0), .INVERT(1)) u_b (
    .clock(clock), .reset_n(rst_b_n), .pat(pat), .pat_en(pat_en),
    .fade_rate(fade_rate), .bright(bright), .led(led_b), .dark(dark_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "led_a";
      1: return "dark_a";
      2: return "lvl_a";
      3: return "led_b";
      4: return "dark_b";
      default: return "lvl_b";
    endcase
  endfunction

  function automatic logic [7:0] actual(input int sel, input logic [2:0] idx);
    case (sel)
      0: return led_a;
      1: return {7'b0, dark_a};
      2: return {4'b0, u_a.r_lvl[idx]};
      3: return led_b;
      4: return {7'b0, dark_b};
      default: return {4'b0, u_b.r_lvl[idx]};
    endcase
  endfunction

  // Kept sorted by target cycle so the monitor only ever looks at the head.
  function automatic void push(input int c, input int sel, input int idx, input logic [7:0] exp);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sel = sel;
    e.idx = idx[2:0];
    e.exp = exp;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endfunction

  always @(negedge clock) begin
    exp_t       e;
    logic [7:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = actual(e.sel, e.idx);
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d] at cycle %0d (due %0d): got %0h expected %0h",
                 sel_name(e.sel), e.idx, cyc, e.cyc, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int base, input int n);
    while (cyc < base + n) tick();
  endtask

  // Holds the chosen instance in reset for 3 cycles; base is the release cycle.
  task automatic do_reset(input bit which_b, output int base);
    tick();
    if (which_b) rst_b_n = 1'b0;
    else         rst_a_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(cyc + k, which_b ? 3 : 0, 0, which_b ? 8'hFF : 8'h00);
      push(cyc + k, which_b ? 4 : 1, 0, 8'h01);
    end
    repeat (3) tick();
    if (which_b) rst_b_n = 1'b1;
    else         rst_a_n = 1'b1;
    base = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;

    // Reset with all bits requested, then steady full-on single LED
    fade_rate = 2'd0; bright = 4'd15; pat = 8'hFF; pat_en = 1'b1;
    do_reset(1'b0, b);
    pat = 8'h01;
    push(b + 2, 2, 0, 8'd0);
    push(b + 3, 2, 0, 8'd15);
    push(b + 3, 2, 1, 8'd0);
    push(b + 3, 0, 0, 8'h00);
    push(b + 3, 1, 0, 8'h01);
    push(b + 4, 1, 0, 8'h00);
    push(b + 20, 1, 0, 8'h00);
    for (int n = 4; n <= 35; n++)
      push(b + n, 0, 0, (((n - 3) % 16) < 15) ? 8'h01 : 8'h00);
    wait_until(b, 36);

    // Fade of LED 7 from 8 to 0, one step per 16 clocks
    fade_rate = 2'd0; bright = 4'd8; pat = 8'h80; pat_en = 1'b1;
    do_reset(1'b0, b);
    push(b + 3, 2, 7, 8'd8);
    push(b + 18, 2, 7, 8'd8);
    push(b + 19, 2, 7, 8'd7);
    push(b + 34, 2, 7, 8'd7);
    push(b + 35, 2, 7, 8'd6);
    push(b + 130, 2, 7, 8'd1);
    push(b + 131, 2, 7, 8'd0);
    push(b + 148, 2, 7, 8'd0);
    push(b + 50, 2, 0, 8'd0);
    push(b + 20, 0, 0, 8'h80);
    push(b + 27, 0, 0, 8'h00);
    push(b + 131, 1, 0, 8'h00);
    push(b + 132, 1, 0, 8'h01);
    wait_until(b, 3);
    pat = 8'h00;
    wait_until(b, 150);

    // Per-bit independence, then load colliding with a decay tick
    fade_rate = 2'd0; bright = 4'd9; pat = 8'h55; pat_en = 1'b1;
    do_reset(1'b0, b);
    push(b + 3, 2, 0, 8'd9);
    push(b + 3, 2, 1, 8'd0);
    push(b + 4, 2, 0, 8'd9);
    push(b + 4, 2, 1, 8'd3);
    push(b + 5, 2, 3, 8'd5);
    push(b + 18, 2, 3, 8'd5);
    push(b + 19, 2, 3, 8'd12);
    push(b + 19, 2, 1, 8'd2);
    push(b + 19, 2, 0, 8'd8);
    push(b + 35, 2, 3, 8'd11);
    wait_until(b, 3);
    pat = 8'hAA; bright = 4'd3;
    wait_until(b, 4);
    pat = 8'h08; bright = 4'd5;
    wait_until(b, 5);
    pat = 8'h00;
    wait_until(b, 18);
    pat = 8'h08; bright = 4'd12;
    wait_until(b, 19);
    pat = 8'h00;
    wait_until(b, 36);

    // fade_rate=3: a decay tick every 4 clocks
    fade_rate = 2'd3; bright = 4'd4; pat = 8'h01; pat_en = 1'b1;
    do_reset(1'b0, b);
    push(b + 6, 2, 0, 8'd4);
    push(b + 7, 2, 0, 8'd3);
    push(b + 10, 2, 0, 8'd3);
    push(b + 11, 2, 0, 8'd2);
    push(b + 15, 2, 0, 8'd1);
    push(b + 19, 2, 0, 8'd0);
    push(b + 23, 2, 0, 8'd0);
    push(b + 19, 1, 0, 8'h00);
    push(b + 20, 1, 0, 8'h01);
    wait_until(b, 3);
    pat = 8'h00;
    wait_until(b, 24);

    // fade_rate=1: a decay tick every 8 clocks
    fade_rate = 2'd1; bright = 4'd2; pat = 8'h01; pat_en = 1'b1;
    do_reset(1'b0, b);
    push(b + 10, 2, 0, 8'd2);
    push(b + 11, 2, 0, 8'd1);
    push(b + 18, 2, 0, 8'd1);
    push(b + 19, 2, 0, 8'd0);
    wait_until(b, 3);
    pat = 8'h00;
    wait_until(b, 20);

    // Inverted outputs: bright=0 stays dark, then async reset mid-fade
    fade_rate = 2'd0; bright = 4'd0; pat = 8'hFF; pat_en = 1'b1;
    do_reset(1'b1, b);
    for (int n = 1; n <= 20; n++) push(b + n, 3, 0, 8'hFF);
    push(b + 5, 4, 0, 8'h01);
    push(b + 20, 4, 0, 8'h01);
    push(b + 10, 5, 0, 8'd0);
    push(b + 21, 5, 0, 8'd15);
    push(b + 22, 3, 0, 8'h00);
    push(b + 22, 4, 0, 8'h00);
    push(b + 24, 3, 0, 8'h00);
    push(b + 24, 5, 0, 8'd15);
    push(b + 25, 3, 0, 8'hFF);
    push(b + 25, 4, 0, 8'h01);
    push(b + 25, 5, 0, 8'd0);
    wait_until(b, 20);
    bright = 4'd15;
    wait_until(b, 22);
    pat = 8'h00;
    wait_until(b, 25);
    rst_b_n = 1'b0;
    repeat (3) tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
